// File: rtl/yari_mem_pkg.sv
// yari memory port constants shared by the core arbiter and the bridge.
// Tags identify the requester so returning read data can be routed.
package yari_mem_pkg;

  localparam logic [1:0] ID_NONE = 2'd0;
  localparam logic [1:0] ID_DC   = 2'd1;
  localparam logic [1:0] ID_IC   = 2'd2;

  localparam int MEM_ADDR_W = 30;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_MASK_W = 4;

  typedef logic [1:0] mem_id_t;

endpackage

// File: rtl/yari_tag_fifo.sv
// In-order FIFO of outstanding read tags for the yari memory bridge.
// Synchronous active-low reset; depth must be a power of two.
module yari_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          push_ok, pop_ok;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // tag storage; contents are don't-care while empty
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_q] <= din;
  end

  // pointers wrap naturally; count tracks occupancy
  always_ff @(posedge clock) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/yari_mem_bridge.sv
// Bridges the tagged yari memory port to an untagged in-order slave.
// Optional perf counters: define YARI_MEM_BRIDGE_STATS_EN.
module yari_mem_bridge
  import yari_mem_pkg::*;
#(
  parameter int TAG_DEPTH = 4,
  parameter int ADDR_W    = MEM_ADDR_W,
  localparam int CW       = $clog2(TAG_DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  rst,
  output logic                  mem_waitrequest,
  input  logic [1:0]            mem_id,
  input  logic [ADDR_W-1:0]     mem_address,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [MEM_DATA_W-1:0] mem_writedata,
  input  logic [MEM_MASK_W-1:0] mem_writedatamask,
  output logic [MEM_DATA_W-1:0] mem_readdata,
  output logic [1:0]            mem_readdataid,
  input  logic                  s_waitrequest,
  output logic [ADDR_W-1:0]     s_address,
  output logic                  s_read,
  output logic                  s_write,
  output logic [MEM_DATA_W-1:0] s_writedata,
  output logic [MEM_MASK_W-1:0] s_byteenable,
  input  logic [MEM_DATA_W-1:0] s_readdata,
  input  logic                  s_readdatavalid,
  output logic                  err
`ifdef YARI_MEM_BRIDGE_STATS_EN
  ,
  output logic [31:0]           perf_reads,
  output logic [31:0]           perf_writes,
  output logic [31:0]           perf_stall_cycles,
  output logic [CW-1:0]         perf_max_outstanding
`endif
);

  logic            rd_req, full, empty;
  logic            push, pop, wr_acc;
  mem_id_t         tag_out;
  logic [CW-1:0]   count;
  logic [MEM_DATA_W-1:0] rdata_q, rdata_d;
  mem_id_t         rid_q, rid_d;
  logic            err_q, err_d;

  assign rd_req          = mem_read & ~mem_write;
  assign s_address       = mem_address;
  assign s_writedata     = mem_writedata;
  assign s_byteenable    = mem_writedatamask;
  assign s_write         = mem_write;
  assign s_read          = rd_req & ~full;
  assign mem_waitrequest = s_waitrequest | (rd_req & full);
  assign push            = s_read & ~s_waitrequest;
  assign wr_acc          = s_write & ~s_waitrequest;
  assign pop             = s_readdatavalid & ~empty;

  yari_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .W     (2)
  ) u_tags (
    .clock (clock),
    .rst   (rst),
    .push  (push),
    .din   (mem_id),
    .pop   (pop),
    .dout  (tag_out),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // response retag and sticky protocol-error detection
  always_comb begin
    rdata_d = rdata_q;
    rid_d   = ID_NONE;
    err_d   = err_q;
    if (pop) begin
      rdata_d = s_readdata;
      rid_d   = tag_out;
    end
    if (mem_read & mem_write)            err_d = 1'b1;
    if (push && mem_id == ID_NONE)       err_d = 1'b1;
    if (s_readdatavalid & empty)         err_d = 1'b1;
  end

  // registered response and error flag
  always_ff @(posedge clock) begin
    if (!rst) begin
      rdata_q <= '0;
      rid_q   <= ID_NONE;
      err_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      rid_q   <= rid_d;
      err_q   <= err_d;
    end
  end

  assign mem_readdata   = rdata_q;
  assign mem_readdataid = rid_q;
  assign err            = err_q;

`ifdef YARI_MEM_BRIDGE_STATS_EN
  logic [31:0]   reads_q, writes_q, stall_q;
  logic [CW-1:0] max_q;

  // accepted-request, stall and high-water counters
  always_ff @(posedge clock) begin
    if (!rst) begin
      reads_q  <= '0;
      writes_q <= '0;
      stall_q  <= '0;
      max_q    <= '0;
    end else begin
      reads_q  <= reads_q + 32'(push);
      writes_q <= writes_q + 32'(wr_acc);
      stall_q  <= stall_q +
                  32'((mem_read | mem_write) & mem_waitrequest);
      if (count > max_q) max_q <= count;
    end
  end

  assign perf_reads           = reads_q;
  assign perf_writes          = writes_q;
  assign perf_stall_cycles    = stall_q;
  assign perf_max_outstanding = max_q;
`else
  logic unused_wr;
  assign unused_wr = wr_acc;
`endif

endmodule
